// File: rtl/matvec_pkg.sv
// ----------------------------------------------------------------------------
// matvec_pkg
// Shared types and constants for the matrix-vector multiplier and its weight
// loader.
//   loader_state_t   : one-hot state encoding of the matrix loader FSM
//   q2_14_t          : signed Q2.14 weight word
//   LOADER_BANDWIDTH : words returned per fetch (also the MAC width)
// ----------------------------------------------------------------------------
package matvec_pkg;

   localparam int LOADER_BANDWIDTH = 16;

   typedef logic signed [15:0] q2_14_t;

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      FETCH = 3'b010,
      READY = 3'b100
   } loader_state_t;

endpackage

// File: rtl/matrix_sram.sv
// ----------------------------------------------------------------------------
// matrix_sram
// Single-port weight memory, DEPTH x DATA_WIDTH, synchronous read with one
// cycle of latency. A read and a write share the single address port; when
// both are requested in the same cycle the read wins and the write is dropped.
// Contents are not reset.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (read register only)
//   re_i    : read strobe
//   we_i    : write strobe
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after re_i
// ----------------------------------------------------------------------------
module matrix_sram
   import matvec_pkg::*;
#(
   parameter  int DEPTH      = 4096,
   parameter  int DATA_WIDTH = 16,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  re_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Memory array write port; a concurrent read takes the port.
   always_ff @(posedge clk) begin
      if (we_i && !re_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Registered read data, one cycle behind the read strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/matrix_loader.sv
// ----------------------------------------------------------------------------
// matrix_loader
// Weight server for the matrix-vector multiplier. On a fetch request it reads
// BANDWIDTH consecutive words starting at a base address from the on-chip
// SRAM into a chunk register, then raises matrix_ready and holds the chunk.
// Slots whose address falls at or beyond DEPTH are zero-filled without
// touching the SRAM.
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   matrix_enable : fetch request, held high until ready is seen
//   matrix_addr   : base word address of the chunk
//   matrix_data   : chunk, element i = mem[base+i] (signed Q2.14)
//   matrix_ready  : chunk valid and stable
//   init_we       : preload write strobe (honoured only in IDLE)
//   init_addr     : preload write address
//   init_data     : preload write data
//   busy          : high in any state but IDLE
// ----------------------------------------------------------------------------
module matrix_loader
   import matvec_pkg::*;
#(
   parameter  int NUM_ROWS   = 64,
   parameter  int NUM_COLS   = 64,
   parameter  int DATA_WIDTH = 16,
   parameter  int BANDWIDTH  = LOADER_BANDWIDTH,
   localparam int DEPTH      = NUM_ROWS * NUM_COLS,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   matrix_enable,
   input  logic [ADDR_WIDTH-1:0]                  matrix_addr,
   output logic [BANDWIDTH-1:0][DATA_WIDTH-1:0]   matrix_data,
   output logic                                   matrix_ready,
   input  logic                                   init_we,
   input  logic [ADDR_WIDTH-1:0]                  init_addr,
   input  logic [DATA_WIDTH-1:0]                  init_data,
   output logic                                   busy
);

   localparam int CNT_W = $clog2(BANDWIDTH + 1);
   localparam int IDX_W = (BANDWIDTH > 1) ? $clog2(BANDWIDTH) : 1;
   localparam int SUM_W = ADDR_WIDTH + 1;

   loader_state_t                         state_q, state_d;
   logic [ADDR_WIDTH-1:0]                 base_q, base_d;
   logic [CNT_W-1:0]                      count_q, count_d;
   logic                                  rd_pend_q, rd_pend_d;
   logic                                  rd_oor_q, rd_oor_d;
   logic [IDX_W-1:0]                      rd_idx_q, rd_idx_d;
   logic                                  ready_q, ready_d;
   logic                                  busy_q, busy_d;
   logic [BANDWIDTH-1:0][DATA_WIDTH-1:0]  chunk_q;

   logic [SUM_W-1:0]                      addr_sum_s;
   logic                                  oor_s;
   logic                                  slot_s;
   logic                                  sram_re_s;
   logic                                  sram_we_s;
   logic [ADDR_WIDTH-1:0]                 sram_addr_s;
   logic [DATA_WIDTH-1:0]                 sram_rdata_s;

   // Slot address, range check and SRAM port arbitration.
   // The sum is one bit wider than the address so slots past the end are
   // detected instead of wrapping back to the start of memory.
   always_comb begin
      addr_sum_s = {1'b0, base_q} + SUM_W'(count_q);
      oor_s      = (addr_sum_s >= SUM_W'(DEPTH));
      slot_s     = (state_q == FETCH) && matrix_enable &&
                   (count_q < CNT_W'(BANDWIDTH));
      sram_re_s  = slot_s && !oor_s;
      sram_we_s  = (state_q == IDLE) && !matrix_enable && init_we;
      if (sram_re_s) begin
         sram_addr_s = addr_sum_s[ADDR_WIDTH-1:0];
      end else begin
         sram_addr_s = init_addr;
      end
   end

   // Next-state logic for the FSM, slot counter and read pipeline tag.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      count_d   = count_q;
      // Every issued slot (read or zero-pad) is tagged so its result lands
      // in the right chunk element one cycle later.
      rd_pend_d = slot_s;
      rd_oor_d  = oor_s;
      rd_idx_d  = count_q[IDX_W-1:0];
      case (state_q)
         IDLE: begin
            if (matrix_enable) begin
               base_d  = matrix_addr;
               count_d = '0;
               state_d = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            if (!matrix_enable) begin
               state_d = IDLE;
            end else begin
               if (slot_s) begin
                  count_d = count_q + CNT_W'(1);
               end else begin
                  count_d = count_q;
               end
               // Leave on the edge that captures the last element.
               if (rd_pend_q && (rd_idx_q == IDX_W'(BANDWIDTH - 1))) begin
                  state_d = READY;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         READY: begin
            if (!matrix_enable) begin
               state_d = IDLE;
            end else begin
               state_d = READY;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == READY);
      busy_d  = (state_d != IDLE);
   end

   // FSM, counter, pipeline tag and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         base_q    <= '0;
         count_q   <= '0;
         rd_pend_q <= 1'b0;
         rd_oor_q  <= 1'b0;
         rd_idx_q  <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         count_q   <= count_d;
         rd_pend_q <= rd_pend_d;
         rd_oor_q  <= rd_oor_d;
         rd_idx_q  <= rd_idx_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   // Chunk register: one element per returned slot, held between fetches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chunk_q <= '0;
      end else if (rd_pend_q) begin
         if (rd_oor_q) begin
            chunk_q[rd_idx_q] <= '0;
         end else begin
            chunk_q[rd_idx_q] <= sram_rdata_s;
         end
      end
   end

   matrix_sram #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_sram (
      .clk     (clk),
      .rst_n   (rst_n),
      .re_i    (sram_re_s),
      .we_i    (sram_we_s),
      .addr_i  (sram_addr_s),
      .wdata_i (init_data),
      .rdata_o (sram_rdata_s)
   );

   assign matrix_data  = chunk_q;
   assign matrix_ready = ready_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_matrix_loader.sv
module tb_matrix_loader;

   typedef logic [15:0][15:0] chunk_t;

   logic         clk;
   logic         rst_n;
   logic         matrix_enable;
   logic [11:0]  matrix_addr;
   chunk_t       matrix_data;
   logic         matrix_ready;
   logic         init_we;
   logic [11:0]  init_addr;
   logic [15:0]  init_data;
   logic         busy;

   int           checks;
   int           failures;
   chunk_t       exp_q [$];
   chunk_t       last_chunk;
   logic [15:0]  model_mem [4096];

   matrix_loader dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .matrix_enable (matrix_enable),
      .matrix_addr   (matrix_addr),
      .matrix_data   (matrix_data),
      .matrix_ready  (matrix_ready),
      .init_we       (init_we),
      .init_addr     (init_addr),
      .init_data     (init_data),
      .busy          (busy)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the flow deadlocks.
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk_eq(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic chunk_t build_exp(input int base);
      chunk_t r;
      for (int i = 0; i < 16; i++) begin
         if (base + i < 4096) r[i] = model_mem[base + i];
         else                 r[i] = 16'h0000;
      end
      return r;
   endfunction

   task automatic chk_chunk(input string tag, input chunk_t exp);
      for (int i = 0; i < 16; i++)
         chk_eq($sformatf("%s[%0d]", tag, i), $signed(matrix_data[i]), $signed(exp[i]));
   endtask

   // Full fetch: push expectation, wait for ready (bounded), pop and compare.
   task automatic do_fetch(input int base, input bit drop, input bit wr_mid);
      chunk_t exp;
      int lat;
      exp_q.push_back(build_exp(base));
      @(negedge clk);
      matrix_enable = 1'b1;
      matrix_addr   = 12'(base);
      @(posedge clk);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (wr_mid && n == 3) begin
            init_we = 1'b1; init_addr = 12'd1; init_data = 16'hBEEF;
         end else begin
            init_we = 1'b0;
         end
         if (matrix_ready) begin
            lat = n;
            break;
         end
         chk_eq($sformatf("busy_fetch_c%0d", n), busy, 1);
      end
      init_we = 1'b0;
      chk_eq($sformatf("ready_latency_b%0d", base), lat, 18);
      chk_eq("busy_at_ready", busy, 1);
      matrix_addr = 12'(base + 100);
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         chk_eq("ready_hold", matrix_ready, 1);
      end
      exp = exp_q.pop_front();
      last_chunk = exp;
      chk_chunk($sformatf("data_b%0d", base), exp);
      if (drop) begin
         matrix_enable = 1'b0;
         @(negedge clk);
         chk_eq("ready_drop", matrix_ready, 0);
         chk_eq("busy_drop", busy, 0);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      matrix_enable = 1'b0;
      matrix_addr = 12'd0;
      init_we = 1'b0;
      init_addr = 12'd0;
      init_data = 16'd0;

      // Reset state
      repeat (2) @(negedge clk);
      chk_eq("rst_ready", matrix_ready, 0);
      chk_eq("rst_busy", busy, 0);
      chk_chunk("rst_data", '0);
      rst_n = 1'b1;

      // Preload mem[i] = i
      for (int i = 0; i < 4096; i++) begin
         @(negedge clk);
         init_we = 1'b1; init_addr = 12'(i); init_data = 16'(i);
         model_mem[i] = 16'(i);
      end
      @(negedge clk);
      init_we = 1'b0;

      // 1. Basic fetch
      do_fetch(0, 1'b1, 1'b0);

      // 4. Hold after drop, then back-to-back
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk_chunk("hold", last_chunk);
      end
      do_fetch(16, 1'b1, 1'b0);

      // 2. Tail pad
      do_fetch(4090, 1'b1, 1'b0);

      // 3. Abort in cycle 5 of FETCH
      @(negedge clk);
      matrix_enable = 1'b1;
      matrix_addr = 12'd40;
      @(posedge clk);
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         chk_eq("abort_ready_low", matrix_ready, 0);
      end
      matrix_enable = 1'b0;
      @(negedge clk);
      chk_eq("abort_idle_busy", busy, 0);
      chk_eq("abort_idle_ready", matrix_ready, 0);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         chk_eq("abort_no_ready", matrix_ready, 0);
      end
      do_fetch(32, 1'b1, 1'b0);

      // 5. Reset in READY
      do_fetch(0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_eq("midrst_ready", matrix_ready, 0);
      chk_eq("midrst_busy", busy, 0);
      chk_chunk("midrst_data", '0);
      matrix_enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_fetch(0, 1'b1, 1'b0);

      // 6. Preload rules: IDLE write honoured, FETCH write ignored
      @(negedge clk);
      init_we = 1'b1; init_addr = 12'd0; init_data = 16'h8000;
      model_mem[0] = 16'h8000;
      @(negedge clk);
      init_we = 1'b0;
      do_fetch(0, 1'b1, 1'b1);
      chk_eq("neg_weight", $signed(matrix_data[0]), -32768);
      do_fetch(0, 1'b1, 1'b0);
      chk_eq("fetch_write_ignored", matrix_data[1], 1);

      chk_eq("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
